// File: rtl/fpu_dot_sequencer.sv
// Dot-product sequencer driving a multiplier FPU and an adder FPU over strobe/ack handshakes.
// Optional: define FPU_DOT_FIRST_BYPASS_EN to load the first product straight into the accumulator.
module fpu_dot_sequencer #(
    parameter int VECTOR_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic [31:0] elem_a,
    input  logic [31:0] elem_b,
    input  logic        elem_stb,
    output logic        elem_ack,
    output logic [31:0] mul_input_a,
    output logic [31:0] mul_input_b,
    output logic        mul_input_stb,
    input  logic        mul_input_ack,
    input  logic [31:0] mul_output_z,
    input  logic        mul_output_stb,
    output logic        mul_output_ack,
    output logic [31:0] add_input_a,
    output logic [31:0] add_input_b,
    output logic        add_input_stb,
    input  logic        add_input_ack,
    input  logic [31:0] add_output_z,
    input  logic        add_output_stb,
    output logic        add_output_ack,
    output logic [31:0] result_z,
    output logic        result_stb,
    input  logic        result_ack
);

    localparam int CW = $clog2(VECTOR_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ELEM,
        MUL_SEND,
        MUL_WAIT,
        ADD_SEND,
        ADD_WAIT,
        OUT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [31:0]     acc;
    logic [31:0]     prod;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            last;
    logic            first;

    assign cnt_inc = cnt + 1'b1;
    assign last    = (cnt_inc == CW'(VECTOR_LEN));
    assign first   = (cnt == '0);

    assign busy           = (state != IDLE);
    assign elem_ack       = (state == GET_ELEM);
    assign mul_input_stb  = (state == MUL_SEND);
    assign mul_output_ack = (state == MUL_WAIT);
    assign add_input_stb  = (state == ADD_SEND);
    assign add_output_ack = (state == ADD_WAIT);
    assign result_stb     = (state == OUT);

    assign add_input_a = acc;
    assign add_input_b = prod;
    // The accumulator is only cleared by start, so the result persists in IDLE.
    assign result_z    = acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = GET_ELEM;
            end
            GET_ELEM: begin
                if (elem_stb) state_nx = MUL_SEND;
            end
            MUL_SEND: begin
                if (mul_input_ack) state_nx = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_output_stb) begin
                    state_nx = ADD_SEND;
`ifdef FPU_DOT_FIRST_BYPASS_EN
                    if (first) state_nx = last ? OUT : GET_ELEM;
`endif
                end
            end
            ADD_SEND: begin
                if (add_input_ack) state_nx = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (add_output_stb) state_nx = last ? OUT : GET_ELEM;
            end
            OUT: begin
                if (result_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            prod        <= '0;
            cnt         <= '0;
            mul_input_a <= '0;
            mul_input_b <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                GET_ELEM: begin
                    if (elem_stb) begin
                        mul_input_a <= elem_a;
                        mul_input_b <= elem_b;
                    end
                end
                MUL_WAIT: begin
                    if (mul_output_stb) begin
`ifdef FPU_DOT_FIRST_BYPASS_EN
                        if (first) begin
                            acc <= mul_output_z;
                            cnt <= cnt_inc;
                        end else begin
                            prod <= mul_output_z;
                        end
`else
                        prod <= mul_output_z;
`endif
                    end
                end
                ADD_WAIT: begin
                    if (add_output_stb) begin
                        acc <= add_output_z;
                        cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// Scoreboard bench for fpu_dot_sequencer with table-driven behavioural FPUs.
// Instance 0 uses VECTOR_LEN=4, instance 1 uses VECTOR_LEN=1.
module tb_fpu_dot_sequencer;

    logic        clk;
    logic        rst;
    logic        start [2];
    logic        busy [2];
    logic [31:0] ea [2];
    logic [31:0] eb [2];
    logic        estb [2];
    logic        eack [2];
    logic [31:0] mia [2];
    logic [31:0] mib [2];
    logic        mistb [2];
    logic        miack [2];
    logic [31:0] moz [2];
    logic        mostb [2];
    logic        moack [2];
    logic [31:0] aia [2];
    logic [31:0] aib [2];
    logic        aistb [2];
    logic        aiack [2];
    logic [31:0] aoz [2];
    logic        aostb [2];
    logic        aoack [2];
    logic [31:0] rz [2];
    logic        rstb [2];
    logic        rack [2];

    int checks;
    int errors;
    int mdly;
    int midly;
    int elem_n [2];
    int add_n [2];
    logic [31:0] last_aia [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic        prev_mstb;
    logic [63:0] prev_mab;
    int lat_meas;

    localparam logic [31:0] VA [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [31:0] VB [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

`ifdef FPU_DOT_FIRST_BYPASS_EN
    localparam int EXP_LAT  = 19;
    localparam int EXP_ADD4 = 3;
    localparam int EXP_ADD1 = 0;
`else
    localparam int EXP_LAT  = 21;
    localparam int EXP_ADD4 = 4;
    localparam int EXP_ADD1 = 1;
`endif

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40A00000}: return 32'h40A00000;
            {32'h40000000, 32'h40C00000}: return 32'h41400000;
            {32'h40400000, 32'h40E00000}: return 32'h41A80000;
            {32'h40800000, 32'h41000000}: return 32'h42000000;
            {32'h40200000, 32'h40800000}: return 32'h41200000;
            default: return 32'h7FC00000;
        endcase
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h40A00000}: return 32'h40A00000;
            {32'h40A00000, 32'h41400000}: return 32'h41880000;
            {32'h41880000, 32'h41A80000}: return 32'h42180000;
            {32'h42180000, 32'h42000000}: return 32'h428C0000;
            {32'h00000000, 32'h41200000}: return 32'h41200000;
            default: return 32'h7FC00000;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic        mpend;
        logic [3:0]  mcnt;
        logic [3:0]  icnt;
        logic [31:0] mres;
        logic        apend;
        logic [31:0] ares;

        fpu_dot_sequencer #(.VECTOR_LEN(g == 0 ? 4 : 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start[g]),
            .busy           (busy[g]),
            .elem_a         (ea[g]),
            .elem_b         (eb[g]),
            .elem_stb       (estb[g]),
            .elem_ack       (eack[g]),
            .mul_input_a    (mia[g]),
            .mul_input_b    (mib[g]),
            .mul_input_stb  (mistb[g]),
            .mul_input_ack  (miack[g]),
            .mul_output_z   (moz[g]),
            .mul_output_stb (mostb[g]),
            .mul_output_ack (moack[g]),
            .add_input_a    (aia[g]),
            .add_input_b    (aib[g]),
            .add_input_stb  (aistb[g]),
            .add_input_ack  (aiack[g]),
            .add_output_z   (aoz[g]),
            .add_output_stb (aostb[g]),
            .add_output_ack (aoack[g]),
            .result_z       (rz[g]),
            .result_stb     (rstb[g]),
            .result_ack     (rack[g])
        );

        assign miack[g] = !mpend && (int'(icnt) >= midly);
        assign mostb[g] = mpend && (mcnt == 4'd0);
        assign moz[g]   = mres;
        assign aiack[g] = !apend;
        assign aostb[g] = apend;
        assign aoz[g]   = ares;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                mpend <= 1'b0;
                mcnt  <= 4'd0;
                icnt  <= 4'd0;
                mres  <= '0;
            end else begin
                if (mistb[g] && !miack[g]) icnt <= icnt + 4'd1;
                else icnt <= 4'd0;
                if (mistb[g] && miack[g]) begin
                    mpend <= 1'b1;
                    mcnt  <= 4'(mdly);
                    mres  <= fmul(mia[g], mib[g]);
                end else if (mostb[g] && moack[g]) begin
                    mpend <= 1'b0;
                end else if (mpend && mcnt != 4'd0) begin
                    mcnt <= mcnt - 4'd1;
                end
            end
        end

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                apend <= 1'b0;
                ares  <= '0;
            end else if (aistb[g] && aiack[g]) begin
                apend <= 1'b1;
                ares  <= fadd(aia[g], aib[g]);
            end else if (aostb[g] && aoack[g]) begin
                apend <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on result transfer, transfer counters, operand hold.
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                if (rstb[g] && rack[g]) begin
                    if (g == 0 && exp_q0.size() > 0) chk("result0", {32'h0, rz[0]}, {32'h0, exp_q0.pop_front()});
                    else if (g == 1 && exp_q1.size() > 0) chk("result1", {32'h0, rz[1]}, {32'h0, exp_q1.pop_front()});
                    else chk("unexpected_result", {32'h0, rz[g]}, 64'hFFFFFFFF_FFFFFFFF);
                end
                if (estb[g] && eack[g]) elem_n[g]++;
                if (aistb[g] && aiack[g]) begin
                    add_n[g]++;
                    last_aia[g] = aia[g];
                end
            end
            if (mistb[0] && prev_mstb) chk("mul_hold", {mia[0], mib[0]}, prev_mab);
            prev_mstb = mistb[0];
            prev_mab  = {mia[0], mib[0]};
        end else begin
            prev_mstb = 1'b0;
        end
    end

    task automatic wait_ack(input int g);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (eack[g]) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("elem_ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic feed(input int g, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            ea[g]   = (g == 0) ? VA[i] : 32'h40200000;
            eb[g]   = (g == 0) ? VB[i] : 32'h40800000;
            estb[g] = 1'b1;
            wait_ack(g);
            estb[g] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int g);
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (!busy[g]) return;
        end
        chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input int g, input int n, input logic [31:0] exp, input bit gaps);
        if (g == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
        @(posedge clk);
        #1 start[g] = 1'b1;
        fork
            begin
                @(posedge clk);
                #1 start[g] = 1'b0;
                feed(g, n, gaps);
            end
            begin
                lat_meas = 0;
                for (int k = 0; k < 500; k++) begin
                    @(posedge clk);
                    #1;
                    lat_meas++;
                    if (rstb[g]) break;
                end
            end
        join
        wait_idle(g);
    endtask

    initial begin
        logic [31:0] held;
        checks = 0;
        errors = 0;
        mdly = 0;
        midly = 0;
        prev_mstb = 1'b0;
        prev_mab = '0;
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0;
            ea[g] = '0;
            eb[g] = '0;
            estb[g] = 1'b0;
            rack[g] = 1'b1;
            elem_n[g] = 0;
            add_n[g] = 0;
            last_aia[g] = 32'hFFFFFFFF;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {57'd0, busy[0], eack[0], mistb[0], moack[0], aistb[0], aoack[0], rstb[0]}, 64'd0);
        chk("reset_data", {32'd0, mia[0] | mib[0] | aia[0] | aib[0] | rz[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait dot product and latency.
        run(0, 4, 32'h428C0000, 1'b0);
        chk("latency", 64'(lat_meas), 64'(EXP_LAT));
        chk("elem_count", 64'(elem_n[0]), 64'd4);
        chk("add_count", 64'(add_n[0]), 64'(EXP_ADD4));

        // Single-term instance.
        run(1, 1, 32'h41200000, 1'b0);
        chk("add_count_len1", 64'(add_n[1]), 64'(EXP_ADD1));
`ifndef FPU_DOT_FIRST_BYPASS_EN
        chk("add_a_len1", {32'd0, last_aia[1]}, 64'd0);
`endif

        // Slow multiplier with producer gaps.
        mdly = 7;
        midly = 3;
        elem_n[0] = 0;
        run(0, 4, 32'h428C0000, 1'b1);
        chk("elem_count_slow", 64'(elem_n[0]), 64'd4);
        mdly = 0;
        midly = 0;

        // Consumer holds off the result for 10 cycles.
        rack[0] = 1'b0;
        fork
            run(0, 4, 32'h428C0000, 1'b0);
            begin
                for (int k = 0; k < 200 && !rstb[0]; k++) @(posedge clk);
                #2;
                held = rz[0];
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    chk("hold_stb", {63'd0, rstb[0]}, 64'd1);
                    chk("hold_z", {32'd0, rz[0]}, {32'd0, held});
                end
                rack[0] = 1'b1;
                @(posedge clk);
                #1;
                chk("stb_fall", {62'd0, rstb[0], busy[0]}, 64'd0);
            end
        join
        run(0, 4, 32'h428C0000, 1'b0);

        // Asynchronous reset during MUL_WAIT of term 2.
        mdly = 7;
        @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        feed(0, 3, 1'b0);
        for (int k = 0; k < 100 && !moack[0]; k++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_ctl", {57'd0, busy[0], eack[0], mistb[0], moack[0], aistb[0], aoack[0], rstb[0]}, 64'd0);
        chk("async_data", {32'd0, mia[0] | mib[0] | aia[0] | aib[0] | rz[0]}, 64'd0);
        mdly = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(0, 4, 32'h428C0000, 1'b0);

        // Start pulse while busy in ADD_WAIT.
        elem_n[0] = 0;
        fork
            run(0, 4, 32'h428C0000, 1'b0);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (aoack[0]) break;
                end
                start[0] = 1'b1;
                @(posedge clk);
                #1 start[0] = 1'b0;
            end
        join
        chk("elem_count_busy", 64'(elem_n[0]), 64'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart", {63'd0, busy[0]}, 64'd0);
        chk("sb_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_dot_sequencer.md
# fpu_dot_sequencer

Upstream driver for the FPU pair used by the matrix multiplier. It accepts a stream of VECTOR_LEN operand pairs and issues each pair to a multiplier FPU over its strobe/ack operand and result handshake. It then issues each product, together with a running sum, to an adder FPU. After the last term it presents the IEEE 754 single-precision dot product to the consumer, for example a matrix-row writer.

## Interface
- VECTOR_LEN, 4, number of terms per dot product; legal range ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins a dot product; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- elem_a, elem_b  in  32  operand pair, IEEE 754 single.
- elem_stb  in  1  producer has a valid pair.
- elem_ack  out  1  sequencer accepts the pair.
- mul_input_a, mul_input_b  out  32  multiplier operands.
- mul_input_stb  out  1  multiplier operands valid.
- mul_input_ack  in  1  multiplier has taken the operands.
- mul_output_z  in  32  product.
- mul_output_stb  in  1  product valid.
- mul_output_ack  out  1  product consumed.
- add_input_a, add_input_b, add_input_stb, add_input_ack, add_output_z, add_output_stb, add_output_ack: the same roles, for the adder.
- result_z  out  32  dot product.
- result_stb  out  1  result valid.
- result_ack  in  1  consumer took the result.

## Operation
- States: IDLE → GET_ELEM → MUL_SEND → MUL_WAIT → ADD_SEND → ADD_WAIT → (GET_ELEM | OUT) → IDLE.
- Transfer rule for every handshake: a transfer occurs on a rising edge where strobe and ack are both high.
- Acks and strobes are decoded from the state:
  - elem_ack = GET_ELEM
  - mul_input_stb = MUL_SEND
  - mul_output_ack = MUL_WAIT
  - add_input_stb = ADD_SEND
  - add_output_ack = ADD_WAIT
  - result_stb = OUT
- IDLE: when start=1, clear the accumulator to 32'h00000000, clear the term counter, and go to GET_ELEM.
- GET_ELEM: on transfer, register elem_a/elem_b onto mul_input_a/b and go to MUL_SEND.
- MUL_SEND: on transfer, go to MUL_WAIT. mul_input_a/b are held stable the whole time mul_input_stb is high.
- MUL_WAIT: on transfer, capture mul_output_z into the product register and go to ADD_SEND.
- ADD_SEND: drive add_input_a = accumulator and add_input_b = product; on transfer, go to ADD_WAIT.
- ADD_WAIT: on transfer, write add_output_z to the accumulator and increment the counter. If the counter reaches VECTOR_LEN, go to OUT; otherwise go to GET_ELEM.
- OUT: result_z = accumulator; on transfer, go to IDLE. result_z holds its value after the transfer until the next start.
- Counter width is $clog2(VECTOR_LEN+1). It never wraps, because the terminal compare precedes any overflow.
- start outside IDLE is ignored. Strobes arriving on handshakes not owned by the current state are ignored.
- Reset (asynchronous, any state):
  - state → IDLE
  - accumulator, product, counter, result_z, mul_input_a/b, add_input_a/b → 0
  - all strobes and acks low, busy low
  - an in-flight FPU transaction is abandoned; the FPUs are reset by the same rst.

## Timing
- Each state lasts at least one cycle and waits indefinitely for its transfer.
- With zero-wait responders (ack or stb already high), a term takes 5 cycles.
- Full operation with zero-wait responders: start edge to result_stb rise = 5·VECTOR_LEN+1 cycles.
- result_stb falls on the cycle after the result_ack transfer.
- Back-to-back: start may be asserted on the cycle IDLE is re-entered.

## Configuration
- FPU_DOT_FIRST_BYPASS_EN defined:
  - For term 0, MUL_WAIT writes the product straight into the accumulator and skips ADD_SEND/ADD_WAIT.
  - The counter increments in MUL_WAIT for term 0 only.
  - Latency is 5·VECTOR_LEN−1 cycles.
  - A −0.0 first product is preserved.
- FPU_DOT_FIRST_BYPASS_EN undefined: every product goes through the adder starting from +0.0, so an all-(−0.0) sum yields +0.0.

## Test plan
- VECTOR_LEN=4, a={1,2,3,4}, b={5,6,7,8}, behavioural FPUs with zero-wait responses → result_z=32'h428C0000 (70.0) and result_stb rises 21 cycles after start (19 with bypass).
- VECTOR_LEN=1, a=2.5 (32'h40200000), b=4.0 → result 32'h41200000. Without bypass, exactly one adder transaction is seen with add_input_a=0; with bypass, zero adder transactions.
- Multiplier output_stb delayed 7 cycles per term, with elem_stb toggled low for random gaps → same 70.0 result. mul_input_a/b stay stable while mul_input_stb is high; no operand pair is dropped or duplicated (exactly 4 elem transfers).
- Hold result_ack=0 for 10 cycles in OUT → result_stb stays high and result_z stays constant. Ack → IDLE next cycle; a start pulse then gives a correct second result.
- Assert rst low during MUL_WAIT of term 2 → every output is 0 asynchronously, before the next edge. After release, a fresh start gives a correct 70.0.
- Pulse start while busy during ADD_WAIT → no effect on the counter or the result; exactly 4 elem transfers.
